// File: rtl/pixel_loader.sv
// pixel_loader: unpacks UART bytes LSB-first into a 1-bit image RAM, pulses
// start when a full frame is written, then holds off until the core is done.
module pixel_loader #(
    parameter int unsigned BYTES_PER_FRAME = 98,
    parameter int unsigned ADDR_W          = 10,
    parameter int unsigned TIMEOUT_CYCLES  = 500000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_rdy,
    input  logic [7:0]        rx_data,
    input  logic              core_done,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_din,
    output logic              start,
    output logic              loading,
    output logic              overrun,
    output logic              frame_abort
);

    localparam int unsigned BCNT_W = (BYTES_PER_FRAME > 1) ? $clog2(BYTES_PER_FRAME) : 1;
    localparam int unsigned TMR_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(BYTES_PER_FRAME - 1);
    localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SHIFT     = 2'd1,
        WAIT_CORE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [BCNT_W-1:0] byte_cnt;
    logic [2:0]        bit_cnt;
    logic [7:0]        shift_reg;
    logic [7:0]        hold_reg;
    logic              hold_valid;
    logic [TMR_W-1:0]  timer;
    logic              start_q;
    logic              abort_q;
    logic              overrun_q;
    logic              last_bit;
    logic              last_byte;

    assign last_bit  = (bit_cnt == 3'd7);
    assign last_byte = (byte_cnt == LAST_BYTE);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; a byte ready at the end of a shift keeps SHIFT busy
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (rx_rdy) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (last_bit) begin
                    if (last_byte) begin
                        state_nxt = WAIT_CORE;
                    end else if (!hold_valid && !rx_rdy) begin
                        state_nxt = IDLE;
                    end
                end
            end
            WAIT_CORE: begin
                if (core_done) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from registered state and datapath
    always_comb begin
        ram_we      = 1'b0;
        ram_addr    = '0;
        ram_din     = 1'b0;
        start       = start_q;
        frame_abort = abort_q;
        overrun     = overrun_q;
        loading     = (state != IDLE) || (byte_cnt != '0);
        if (state == SHIFT) begin
            ram_we   = 1'b1;
            ram_addr = ADDR_W'({byte_cnt, 3'b000}) + ADDR_W'(bit_cnt);
            ram_din  = shift_reg[0];
        end
    end

    // Datapath: shift/hold registers, counters, timeout and status flags
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_cnt   <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            hold_reg   <= '0;
            hold_valid <= 1'b0;
            timer      <= '0;
            start_q    <= 1'b0;
            abort_q    <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            start_q <= 1'b0;
            abort_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (rx_rdy) begin
                        shift_reg <= rx_data;
                        bit_cnt   <= '0;
                        timer     <= '0;
                    end else if (byte_cnt != '0) begin
                        if (timer == TMR_LAST) begin
                            byte_cnt <= '0;
                            timer    <= '0;
                            abort_q  <= 1'b1;
                        end else begin
                            timer <= timer + TMR_W'(1);
                        end
                    end
                end
                SHIFT: begin
                    shift_reg <= shift_reg >> 1;
                    bit_cnt   <= bit_cnt + 3'd1;
                    if (!last_bit) begin
                        if (rx_rdy) begin
                            if (hold_valid) begin
                                overrun_q <= 1'b1;
                            end else begin
                                hold_reg   <= rx_data;
                                hold_valid <= 1'b1;
                            end
                        end
                    end else if (last_byte) begin
                        // Frame complete: anything buffered belongs to no frame
                        byte_cnt   <= '0;
                        start_q    <= 1'b1;
                        hold_valid <= 1'b0;
                        if (hold_valid || rx_rdy) begin
                            overrun_q <= 1'b1;
                        end
                    end else begin
                        byte_cnt <= byte_cnt + BCNT_W'(1);
                        if (hold_valid) begin
                            shift_reg  <= hold_reg;
                            hold_valid <= 1'b0;
                            if (rx_rdy) begin
                                overrun_q <= 1'b1;
                            end
                        end else if (rx_rdy) begin
                            // Empty hold: the arriving byte goes straight in
                            shift_reg <= rx_data;
                        end
                    end
                end
                WAIT_CORE: begin
                    if (rx_rdy) begin
                        overrun_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_loader.sv
// tb_pixel_loader: directed and randomized checks of pixel_loader against a
// timing-level model of byte acceptance and pixel write scheduling.
module tb_pixel_loader;

    localparam int unsigned BPF = 98;
    localparam int unsigned AW  = 10;
    localparam int unsigned TO  = 50;

    logic          clk;
    logic          rst;
    logic          rx_rdy;
    logic [7:0]    rx_data;
    logic          core_done;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic          ram_din;
    logic          start;
    logic          loading;
    logic          overrun;
    logic          frame_abort;

    pixel_loader #(
        .BYTES_PER_FRAME (BPF),
        .ADDR_W          (AW),
        .TIMEOUT_CYCLES  (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_rdy      (rx_rdy),
        .rx_data     (rx_data),
        .core_done   (core_done),
        .ram_we      (ram_we),
        .ram_addr    (ram_addr),
        .ram_din     (ram_din),
        .start       (start),
        .loading     (loading),
        .overrun     (overrun),
        .frame_abort (frame_abort)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int addr;
        int din;
    } wr_t;

    // Monitor: every observed write and pulse, with its cycle index
    wr_t wq[$];
    wr_t mw;
    int  start_cnt;
    int  start_cyc;
    int  abort_cnt;
    int  abort_cyc;
    always @(negedge clk) begin
        if (ram_we === 1'b1) begin
            mw.cyc  = cyc;
            mw.addr = int'(ram_addr);
            mw.din  = int'(ram_din);
            wq.push_back(mw);
        end
        if (start === 1'b1) begin
            start_cnt = start_cnt + 1;
            start_cyc = cyc;
        end
        if (frame_abort === 1'b1) begin
            abort_cnt = abort_cnt + 1;
            abort_cyc = cyc;
        end
    end

    int  n_checks;
    int  n_errors;
    wr_t eq[$];

    task automatic check(input string tag, input int idx, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s[%0d]: observed %0d expected %0d", tag, idx, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b);
        rx_data = b;
        rx_rdy  = 1'b1;
        @(negedge clk);
        rx_rdy  = 1'b0;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        rx_rdy    = 1'b0;
        core_done = 1'b0;
        tick(2);
        rst = 1'b0;
    endtask

    // Byte k of a frame fills pixels 8k..8k+7, LSB first, from cycle st
    task automatic add_byte(input int k, input logic [7:0] b, input int st);
        wr_t w;
        for (int i = 0; i < 8; i++) begin
            w.cyc  = st + i;
            w.addr = 8 * k + i;
            w.din  = int'(b[i]);
            eq.push_back(w);
        end
    endtask

    task automatic compare_writes(input string tag, input int base);
        int n;
        n = wq.size() - base;
        check({tag, "_count"}, 0, n, eq.size());
        for (int i = 0; i < eq.size() && i < n; i++) begin
            check({tag, "_addr"}, i, wq[base + i].addr, eq[i].addr);
            check({tag, "_din"},  i, wq[base + i].din,  eq[i].din);
            check({tag, "_cyc"},  i, wq[base + i].cyc,  eq[i].cyc);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_we"},    0, ram_we,      0);
        check({tag, "_addr"},  0, ram_addr,    0);
        check({tag, "_din"},   0, ram_din,     0);
        check({tag, "_start"}, 0, start,       0);
        check({tag, "_load"},  0, loading,     0);
        check({tag, "_ovr"},   0, overrun,     0);
        check({tag, "_abort"}, 0, frame_abort, 0);
    endtask

    initial begin
        int         base;
        int         t;
        int         e;
        int         s0;
        int         a0;
        int         last_start;
        int         nacc;
        int         gap;
        int         hi;
        logic       exp_ovr;
        logic [7:0] b;

        rst       = 1'b1;
        rx_rdy    = 1'b0;
        rx_data   = 8'h00;
        core_done = 1'b0;

        // Reset state
        tick(1);
        check_all_zero("reset");
        tick(2);
        rst = 1'b0;

        // Single byte 0xA5
        base = wq.size(); eq.delete();
        t = cyc; send(8'hA5); add_byte(0, 8'hA5, t + 1);
        tick(12);
        compare_writes("one_byte", base);
        check("one_byte_loading", 0, loading, 1);
        check("one_byte_start", 0, start_cnt, 0);

        // Full frame of 0xFF, then a byte in WAIT_CORE, then core_done
        do_reset();
        base = wq.size(); eq.delete(); s0 = start_cnt; a0 = abort_cnt;
        for (int k = 0; k < int'(BPF); k++) begin
            t = cyc; send(8'hFF); add_byte(k, 8'hFF, t + 1);
            tick(39);
        end
        tick(5);
        compare_writes("frame", base);
        check("frame_start_cnt", 0, start_cnt - s0, 1);
        check("frame_start_cyc", 0, start_cyc, eq[eq.size() - 1].cyc + 1);
        check("frame_abort_cnt", 0, abort_cnt - a0, 0);
        check("frame_loading", 0, loading, 1);
        check("frame_ovr", 0, overrun, 0);
        base = wq.size();
        send(8'h3C); tick(10);
        check("wait_drop_writes", 0, wq.size() - base, 0);
        check("wait_drop_ovr", 0, overrun, 1);
        check("wait_loading", 0, loading, 1);
        core_done = 1'b1; tick(1); core_done = 1'b0; tick(1);
        check("released_loading", 0, loading, 0);
        base = wq.size(); eq.delete();
        t = cyc; send(8'h5A); add_byte(0, 8'h5A, t + 1);
        tick(12);
        compare_writes("after_core", base);
        check("after_core_start_cnt", 0, start_cnt - s0, 1);

        // Two strobes 3 cycles apart stream back to back through the hold buffer
        do_reset();
        base = wq.size(); eq.delete();
        t = cyc; send(8'h01); tick(2); send(8'h80);
        add_byte(0, 8'h01, t + 1); add_byte(1, 8'h80, t + 9);
        tick(20);
        compare_writes("b2b", base);
        check("b2b_ovr", 0, overrun, 0);

        // Third strobe while the hold is occupied is dropped
        do_reset();
        base = wq.size(); eq.delete();
        t = cyc; send(8'h01); tick(2); send(8'h80); send(8'hFF);
        add_byte(0, 8'h01, t + 1); add_byte(1, 8'h80, t + 9);
        tick(20);
        compare_writes("drop3", base);
        check("drop3_ovr", 0, overrun, 1);

        // Ten bytes then silence: frame discarded after TO idle cycles
        do_reset();
        base = wq.size(); eq.delete(); a0 = abort_cnt;
        for (int k = 0; k < 10; k++) begin
            b = 8'($urandom);
            t = cyc; send(b); add_byte(k, b, t + 1);
            tick(11);
        end
        e = eq[eq.size() - 1].cyc;
        while (cyc < e + int'(TO) + 5) tick(1);
        compare_writes("timeout", base);
        check("timeout_abort_cnt", 0, abort_cnt - a0, 1);
        check("timeout_abort_cyc", 0, abort_cyc, e + int'(TO) + 1);
        check("timeout_loading", 0, loading, 0);
        base = wq.size(); eq.delete();
        t = cyc; send(8'hC3); add_byte(0, 8'hC3, t + 1);
        tick(12);
        compare_writes("post_abort", base);

        // A byte arriving in the expiry cycle continues the frame
        do_reset();
        base = wq.size(); eq.delete(); a0 = abort_cnt;
        for (int k = 0; k < 3; k++) begin
            b = 8'($urandom);
            t = cyc; send(b); add_byte(k, b, t + 1);
            tick(11);
        end
        e = eq[eq.size() - 1].cyc;
        while (cyc < e + int'(TO)) tick(1);
        b = 8'($urandom);
        t = cyc; send(b); add_byte(3, b, t + 1);
        tick(12);
        compare_writes("expiry_edge", base);
        check("expiry_edge_abort", 0, abort_cnt - a0, 0);
        check("expiry_edge_loading", 0, loading, 1);

        // Reset on the 4th shift cycle of byte 5
        do_reset();
        base = wq.size(); eq.delete();
        for (int k = 0; k < 5; k++) begin
            b = 8'($urandom);
            t = cyc; send(b); add_byte(k, b, t + 1);
            tick(11);
        end
        b = 8'($urandom);
        t = cyc; send(b); add_byte(5, b, t + 1);
        repeat (4) void'(eq.pop_back());
        tick(3);
        rst = 1'b1;
        tick(1);
        check_all_zero("mid_rst");
        rst = 1'b0;
        tick(2);
        compare_writes("mid_rst_wr", base);
        base = wq.size(); eq.delete();
        b = 8'($urandom);
        t = cyc; send(b); add_byte(0, b, t + 1);
        tick(12);
        compare_writes("post_rst", base);

        // Random bytes and spacing: a byte is dropped when the previous
        // accepted byte has not yet begun writing; otherwise it starts
        // writing one cycle after its strobe or right after the previous byte.
        for (int r = 0; r < 3; r++) begin
            do_reset();
            base = wq.size(); eq.delete(); a0 = abort_cnt;
            last_start = -100; nacc = 0; exp_ovr = 1'b0;
            hi = (r == 0) ? 16 : ((r == 1) ? 10 : 6);
            for (int n = 0; n < 30; n++) begin
                gap = int'($urandom_range(hi, 1));
                b = 8'($urandom);
                t = cyc;
                if (t < last_start) begin
                    exp_ovr = 1'b1;
                end else begin
                    last_start = (t + 1 > last_start + 8) ? t + 1 : last_start + 8;
                    add_byte(nacc, b, last_start);
                    nacc++;
                end
                send(b);
                if (gap > 1) tick(gap - 1);
            end
            tick(30);
            compare_writes("rand", base);
            check("rand_ovr", r, overrun, exp_ovr);
            check("rand_abort", r, abort_cnt - a0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
